// File: rtl/cc_decoder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cc_decoder : serial (7,4) cyclic Hamming decoder, g(x)=x^3+x+1, SEC.       |
// | Optional CC_DEC_ERR_CNT_EN adds a saturating corrected-frame counter.     |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
module cc_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_in,
    input  logic       in_valid,
    output logic [3:0] data_out,
    output logic       out_valid,
    output logic       err_corrected,
    output logic [2:0] syndrome
`ifdef CC_DEC_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam logic [2:0] BIT_0 = 3'd0;
    localparam logic [2:0] BIT_6 = 3'd6;

    logic [2:0] r_bit_cnt;
    logic [2:0] r_lfsr;
    logic [5:0] r_buf;

    logic       w_fb;
    logic [2:0] w_syn_nxt;
    logic [6:0] w_code_nxt;
    logic       w_done;
    logic [3:0] w_flip;

    assign w_fb       = r_lfsr[2];
    assign w_syn_nxt  = {r_lfsr[1], r_lfsr[0] ^ w_fb, code_in ^ w_fb};
    assign w_code_nxt = {r_buf, code_in};
    assign w_done     = in_valid && (r_bit_cnt == BIT_6);

    // Only message positions c6..c3 matter; parity-bit errors need no repair.
    always_comb begin
        w_flip = 4'b0000;
        case (w_syn_nxt)
            3'b011:  w_flip = 4'b0001;
            3'b110:  w_flip = 4'b0010;
            3'b111:  w_flip = 4'b0100;
            3'b101:  w_flip = 4'b1000;
            default: w_flip = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt     <= BIT_0;
            r_lfsr        <= 3'b000;
            r_buf         <= 6'b000000;
            data_out      <= 4'b0000;
            out_valid     <= 1'b0;
            err_corrected <= 1'b0;
            syndrome      <= 3'b000;
        end else begin
            out_valid <= w_done;
            if (in_valid) begin
                r_buf <= w_code_nxt[5:0];
                if (w_done) begin
                    r_bit_cnt     <= BIT_0;
                    r_lfsr        <= 3'b000;
                    data_out      <= w_code_nxt[6:3] ^ w_flip;
                    syndrome      <= w_syn_nxt;
                    err_corrected <= (w_syn_nxt != 3'b000);
                end else begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_lfsr    <= w_syn_nxt;
                end
            end
        end
    end

`ifdef CC_DEC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_done && (w_syn_nxt != 3'b000) && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cc_decoder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_cc_decoder : self-checking bench for cc_decoder with polynomial model. |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
module tb_cc_decoder;

    localparam int TB_CNT_W = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       code_in;
    logic       in_valid;
    logic [3:0] data_out;
    logic       out_valid;
    logic       err_corrected;
    logic [2:0] syndrome;
`ifdef CC_DEC_ERR_CNT_EN
    logic [TB_CNT_W-1:0] err_count;
`endif

    cc_decoder #(.ERR_CNT_W(TB_CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .code_in       (code_in),
        .in_valid      (in_valid),
        .data_out      (data_out),
        .out_valid     (out_valid),
        .err_corrected (err_corrected),
        .syndrome      (syndrome)
`ifdef CC_DEC_ERR_CNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every observed pulse is logged with its cycle stamp.
    logic [3:0] q_data[$];
    logic [2:0] q_syn[$];
    logic       q_err[$];
    int         q_cyc[$];
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_data.push_back(data_out);
            q_syn.push_back(syndrome);
            q_err.push_back(err_corrected);
            q_cyc.push_back(cyc);
        end
    end

    logic [6:0] e_rx[$];
    int         e_cyc[$];

    int n_tests = 0;
    int n_fail  = 0;
    int last_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Remainder of a 7-bit polynomial divided by x^3+x+1.
    function automatic logic [2:0] pmod(input logic [6:0] v);
        logic [6:0] r;
        r = v;
        for (int i = 6; i >= 3; i--)
            if (r[i]) r = r ^ (7'b0001011 << (i - 3));
        return r[2:0];
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] m);
        return {m, pmod({m, 3'b000})};
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b0;
            code_in  = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        code_in  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_code(input logic [6:0] code, input int gap_pct);
        for (int i = 6; i >= 0; i--) begin
            for (int g = 0; g < 3; g++)
                if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1);
            send_bit(code[i]);
        end
        last_cyc = cyc;
        e_rx.push_back(code);
        e_cyc.push_back(last_cyc);
    endtask

    // Pops one expected frame and one observed pulse and compares them.
    task automatic check_next(input string tag);
        logic [6:0] rx, fixed;
        logic [2:0] s;
        int         ec;
        rx = e_rx.pop_front();
        ec = e_cyc.pop_front();
        s  = pmod(rx);
        fixed = rx;
        if (s != 3'b000)
            for (int k = 0; k < 7; k++)
                if (pmod(7'(1 << k)) == s) fixed[k] = ~fixed[k];
        chk({tag, "_pulse"}, 32'(q_data.size() > 0), 32'd1);
        if (q_data.size() > 0) begin
            chk({tag, "_data"}, 32'(q_data.pop_front()), 32'(fixed[6:3]));
            chk({tag, "_syn"},  32'(q_syn.pop_front()),  32'(s));
            chk({tag, "_err"},  32'(q_err.pop_front()),  32'(s != 3'b000));
            chk({tag, "_cyc"},  32'(q_cyc.pop_front()),  32'(ec));
        end
    endtask

    task automatic check_all(input string tag);
        while (e_rx.size() > 0) check_next(tag);
        chk({tag, "_no_extra_pulse"}, 32'(q_data.size()), 32'd0);
        q_data.delete(); q_syn.delete(); q_err.delete(); q_cyc.delete();
    endtask

    initial begin
        logic [6:0] c;
        logic [3:0] m;
        int         p1, p2, kind;

        reset = 1'b1; in_valid = 1'b0; code_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",  32'(data_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_err",   32'(err_corrected), 32'd0);
        chk("rst_syn",   32'(syndrome), 32'd0);
`ifdef CC_DEC_ERR_CNT_EN
        chk("rst_cnt",   32'(err_count), 32'd0);
`endif
        reset = 1'b0;
        idle(1);

        send_code(7'b1011000, 0);
        idle(1);
        check_all("basic");

        send_code(7'b0001011, 0);
        send_code(7'b1000101, 0);
        send_code(7'b1111111, 0);
        send_code(7'b0000000, 0);
        idle(2);
        check_all("b2b");

        send_code(7'b0011000, 0);
        send_code(7'b1011001, 0);
        idle(2);
        check_all("single_err");

        // Gapped frame: 3 idle cycles after bit 2, 1 after bit 5.
        c = 7'b0001011;
        for (int i = 6; i >= 0; i--) begin
            send_bit(c[i]);
            if (i == 4) idle(3);
            if (i == 1) idle(1);
        end
        last_cyc = cyc;
        e_rx.push_back(c);
        e_cyc.push_back(last_cyc);
        idle(2);
        check_all("gapped");

        // Partial frame is dropped by a mid-frame reset.
        c = 7'b1000101;
        for (int i = 6; i >= 3; i--) send_bit(c[i]);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_code(7'b1111111, 0);
        idle(2);
        check_all("mid_reset");

        // Reset during the output pulse clears it at once.
        send_code(enc(4'b0110), 0);
        chk("pulse_before_reset", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("pulse_async_clear", 32'(out_valid), 32'd0);
        chk("data_async_clear",  32'(data_out), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        e_rx.delete(); e_cyc.delete();
        idle(1);
        check_all("pulse_reset");

        // Random frames: clean, single and double errors, random gaps.
        for (int f = 0; f < 40; f++) begin
            m    = 4'($urandom);
            c    = enc(m);
            kind = $urandom_range(5);
            p1   = $urandom_range(6);
            p2   = (p1 + 1 + $urandom_range(5)) % 7;
            if (kind >= 1) c[p1] = ~c[p1];
            if (kind == 5) c[p2] = ~c[p2];
            send_code(c, (f % 2 == 0) ? 25 : 0);
        end
        idle(2);
        check_all("rand");

`ifdef CC_DEC_ERR_CNT_EN
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            c  = enc(4'($urandom));
            p1 = $urandom_range(6);
            c[p1] = ~c[p1];
            send_code(c, 0);
            idle(1);
            chk($sformatf("cnt_%0d", f), 32'(err_count), 32'((f > 3) ? 3 : f));
        end
        check_all("cnt_frames");
        reset = 1'b1;
        #1;
        chk("cnt_reset", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
